vend_datapath: RTL
==================

VEND_DATAPATH -- requirements
Module: vend_datapath

Interface
REQ-001 WIDTH, 8, bit width of the total, change and remaining-change registers.
REQ-002 PRICE, 45, item price in cents; SHALL be a multiple of 5 and less than 2**WIDTH.
REQ-003 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 coin_valid  in  1  coin offered this cycle.
REQ-006 coin_type  in  2  coin code: 00 = nickel (5), 01 = dime (10), 10 = quarter (25), 11 = invalid.
REQ-007 coin_ready  out  1  coin accepted when coin_valid is also high; equals y_ld && !chg_busy.
REQ-008 coin_reject  out  1  one-cycle pulse when a coin with code 11 is offered while coin_ready is high.
REQ-009 y_ld / y_rst  in  1 each  coin-register load and clear strobes from the controller.
REQ-010 total_ld / total_rst  in  1 each  total-accumulator load and clear strobes.
REQ-011 change_ld / change_rst  in  1 each  change-register load and clear strobes.
REQ-012 comp_result  out  1  combinational, total >= PRICE.
REQ-013 total  out  WIDTH  accumulated credit.
REQ-014 change  out  WIDTH  last computed change amount.
REQ-015 chg_coin_valid  out  1  dispenser is offering a change coin.
REQ-016 chg_coin_type  out  2  code of the offered change coin (00, 01 or 10 only).
REQ-017 chg_coin_ready  in  1  coin hopper accepts the offered change coin.
REQ-018 chg_busy  out  1  dispenser not idle.
REQ-019 sale_count  out  16  completed sales counter (see REQ-032).

Function
REQ-020 y register: y_rst clears it to 0 (priority over y_ld); y_ld with an accepted valid coin loads that coin's value; y_ld without an accepted valid coin loads 0.
REQ-021 total register: total_rst clears it to 0 (priority); total_ld loads total+y, saturating at 2**WIDTH-1; otherwise it holds.
REQ-022 Latency: a coin accepted at edge N appears in y after N and in total after N+1; comp_result follows total combinationally.
REQ-023 change register: change_rst clears it to 0 (priority); change_ld loads total-PRICE when total >= PRICE, else 0. The value used is the pre-edge total, so a simultaneous total_rst does not affect it.
REQ-024 Dispenser FSM states: CHG_IDLE and CHG_PAY. From CHG_IDLE, change_ld with a nonzero computed change loads remain with that value and moves to CHG_PAY.
REQ-025 In CHG_PAY, chg_coin_valid = 1 and chg_coin_type selects the largest coin not exceeding remain (quarter, then dime, then nickel).
REQ-026 Handshake: chg_coin_valid and chg_coin_type stay stable until chg_coin_ready is high. On the accepting edge, remain decreases by the coin value. If the new remain is less than 5, the FSM returns to CHG_IDLE and any residue is discarded.
REQ-027 change_ld while the dispenser is in CHG_PAY updates the change register only; the dispenser ignores it.
REQ-028 chg_busy = (state == CHG_PAY); coin_ready stays low while chg_busy is high.

Reset
REQ-029 While rst_n is low at an edge: y, total, change, remain and sale_count clear to 0; the FSM enters CHG_IDLE. Therefore comp_result, coin_reject, chg_coin_valid and chg_busy are 0, including when reset occurs mid-dispense.

Configuration
REQ-030 Macro VEND_DATAPATH_SALE_COUNT_EN compiles the sale counter in.
REQ-031 Without VEND_DATAPATH_SALE_COUNT_EN, sale_count SHALL be tied to 0.
REQ-032 With VEND_DATAPATH_SALE_COUNT_EN, sale_count increments by 1 on each change_ld where total >= PRICE, wrapping from 0xFFFF to 0.

Structure
REQ-033 Package vend_pkg SHALL hold: the coin_e enum, coin value constants 5/10/25, the chg_state_t enum and the default PRICE.
REQ-034 The change dispenser (REQ-024 to REQ-028) SHALL be sub-module vend_change_dispenser.

Verification (PRICE = 45, WIDTH = 8)
REQ-035 rst_n low for 2 cycles with random inputs -> all outputs 0 and chg_busy 0.
REQ-036 Two quarters, with y_ld and total_ld held high -> total reads 25 then 50; comp_result rises in the same cycle total becomes 50.
REQ-037 change_ld with total = 50 and total_rst high -> change = 5, total = 0, one nickel offered, chg_busy falls on the edge chg_coin_ready is high.
REQ-038 total = 85, change_ld, chg_coin_ready low for 3 cycles -> change = 40; coins offered quarter, dime, nickel, each held stable until ready; 3 handshakes total.
REQ-039 coin_type 11 offered -> coin_reject pulses for one cycle and total is unchanged; a quarter offered while chg_busy -> coin_ready 0 and total is unchanged.
REQ-040 rst_n low during the second change coin -> chg_coin_valid is 0 after the edge; with the macro enabled, sale_count returns from 2 to 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared coin codes, coin values, dispenser states and default price for the
// vending datapath and its change dispenser.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NICKEL  = 2'b00,
    COIN_DIME    = 2'b01,
    COIN_QUARTER = 2'b10,
    COIN_INVALID = 2'b11
  } coin_e;

  localparam int unsigned NICKEL_VALUE  = 5;
  localparam int unsigned DIME_VALUE    = 10;
  localparam int unsigned QUARTER_VALUE = 25;

  typedef enum logic {
    CHG_IDLE = 1'b0,
    CHG_PAY  = 1'b1
  } chg_state_t;

  localparam int unsigned DEFAULT_PRICE = 45;

  // Cent value of a coin code; an invalid code is worth nothing.
  function automatic int unsigned coin_value(coin_e c);
    int unsigned v;
    v = 0;
    case (c)
      COIN_NICKEL:  v = NICKEL_VALUE;
      COIN_DIME:    v = DIME_VALUE;
      COIN_QUARTER: v = QUARTER_VALUE;
      default:      v = 0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Change dispenser: pays out a loaded change amount greedily (quarter, dime,
// nickel) over a valid/ready handshake to the coin hopper.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] amount_i,
  input  logic             chg_coin_ready_i,
  output logic             chg_coin_valid_o,
  output logic [1:0]       chg_coin_type_o,
  output logic             chg_busy_o
);

  localparam logic [WIDTH-1:0] NICKEL_W  = WIDTH'(NICKEL_VALUE);
  localparam logic [WIDTH-1:0] DIME_W    = WIDTH'(DIME_VALUE);
  localparam logic [WIDTH-1:0] QUARTER_W = WIDTH'(QUARTER_VALUE);

  chg_state_t       state_q, state_d;
  logic [WIDTH-1:0] remain_q, remain_d;
  logic [WIDTH-1:0] pay_value;
  logic [WIDTH-1:0] remain_after;
  coin_e            pay_coin;

  // The offered coin depends only on remain_q, so it cannot change while the hopper stalls.
  always_comb begin
    if (remain_q >= QUARTER_W) begin
      pay_coin  = COIN_QUARTER;
      pay_value = QUARTER_W;
    end else if (remain_q >= DIME_W) begin
      pay_coin  = COIN_DIME;
      pay_value = DIME_W;
    end else begin
      pay_coin  = COIN_NICKEL;
      pay_value = NICKEL_W;
    end
    remain_after = (remain_q > pay_value) ? (remain_q - pay_value) : '0;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
    state_d          = state_q;
    remain_d         = remain_q;
    chg_coin_valid_o = 1'b0;
    chg_coin_type_o  = COIN_NICKEL;
    case (state_q)
      CHG_IDLE: begin
        if (load_i && (amount_i != '0)) begin
          remain_d = amount_i;
          state_d  = CHG_PAY;
        end
      end
      CHG_PAY: begin
        chg_coin_valid_o = 1'b1;
        chg_coin_type_o  = pay_coin;
        if (chg_coin_ready_i) begin
          // A residue below the smallest coin cannot be paid and is dropped.
          if (remain_after < NICKEL_W) begin
            remain_d = '0;
            state_d  = CHG_IDLE;
          end else begin
            remain_d = remain_after;
          end
        end
      end
      default: begin
        remain_d = '0;
        state_d  = CHG_IDLE;
      end
    endcase
  end

  // NOTE: reset is synchronous (only clk in the sensitivity list) and state uses
  // non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= CHG_IDLE;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  assign chg_busy_o = (state_q == CHG_PAY);

endmodule

// File: rtl/vend_datapath.sv
// Vending machine datapath: coin register, saturating credit total, change
// register and change dispenser. Define VEND_DATAPATH_SALE_COUNT_EN to build
// in the completed-sale counter; otherwise sale_count is tied to zero.
module vend_datapath
  import vend_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PRICE = DEFAULT_PRICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_valid,
  input  logic [1:0]       coin_type,
  output logic             coin_ready,
  output logic             coin_reject,
  input  logic             y_ld,
  input  logic             y_rst,
  input  logic             total_ld,
  input  logic             total_rst,
  input  logic             change_ld,
  input  logic             change_rst,
  output logic             comp_result,
  output logic [WIDTH-1:0] total,
  output logic [WIDTH-1:0] change,
  output logic             chg_coin_valid,
  output logic [1:0]       chg_coin_type,
  input  logic             chg_coin_ready,
  output logic             chg_busy,
  output logic [15:0]      sale_count
);

  localparam logic [WIDTH-1:0] PRICE_W = WIDTH'(PRICE);

  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] total_q, total_d;
  logic [WIDTH-1:0] change_q, change_d;
  logic [WIDTH-1:0] change_calc;
  logic [WIDTH:0]   total_sum;
  logic             reject_q, reject_d;
  logic             coin_accept;
  logic             coin_bad;
  coin_e            coin_code;

  assign coin_code   = coin_e'(coin_type);
  assign coin_ready  = y_ld && !chg_busy;
  assign coin_accept = coin_valid && coin_ready;
  assign coin_bad    = coin_accept && (coin_code == COIN_INVALID);

  assign comp_result = (total_q >= PRICE_W);
  assign change_calc = comp_result ? (total_q - PRICE_W) : '0;

  // One extra bit catches the carry so the total pins at all-ones instead of wrapping.
  assign total_sum = {1'b0, total_q} + {1'b0, y_q};

  always_comb begin
    y_d = y_q;
    if (y_rst) begin
      y_d = '0;
    end else if (y_ld) begin
      y_d = (coin_accept && !coin_bad) ? WIDTH'(coin_value(coin_code)) : '0;
    end

    total_d = total_q;
    if (total_rst) begin
      total_d = '0;
    end else if (total_ld) begin
      total_d = total_sum[WIDTH] ? '1 : total_sum[WIDTH-1:0];
    end

    change_d = change_q;
    if (change_rst) begin
      change_d = '0;
    end else if (change_ld) begin
      change_d = change_calc;
    end

    reject_d = coin_bad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q      <= '0;
      total_q  <= '0;
      change_q <= '0;
      reject_q <= 1'b0;
    end else begin
      y_q      <= y_d;
      total_q  <= total_d;
      change_q <= change_d;
      reject_q <= reject_d;
    end
  end

  assign total       = total_q;
  assign change      = change_q;
  assign coin_reject = reject_q;

  // The dispenser sees the same pre-edge change value the change register loads.
  vend_change_dispenser #(
    .WIDTH (WIDTH)
  ) u_dispenser (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_i           (change_ld),
    .amount_i         (change_calc),
    .chg_coin_ready_i (chg_coin_ready),
    .chg_coin_valid_o (chg_coin_valid),
    .chg_coin_type_o  (chg_coin_type),
    .chg_busy_o       (chg_busy)
  );

`ifdef VEND_DATAPATH_SALE_COUNT_EN
  logic [15:0] sale_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sale_count_q <= '0;
    end else if (change_ld && comp_result) begin
      sale_count_q <= sale_count_q + 16'd1;
    end
  end

  assign sale_count = sale_count_q;
`else
  assign sale_count = '0;
`endif

endmodule
